// File: rtl/booth_final_adder_if.sv
// Handshake bundle between the compressor tree, the final adder and the result register.
// Carries both sides: operand pair (in_*) and resolved product (out_*).
// master = producer of operands / consumer of product; slave = the adder itself.
interface booth_final_adder_if #(
  parameter int PROD_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] pp_sum;
  logic [PROD_W-3:0] pp_carry;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;

  modport master (
    output in_valid, pp_sum, pp_carry, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, pp_sum, pp_carry, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth_final_adder.sv
// Purpose: resolves Booth sum/carry vectors into a 16b product with a SLICE_W-bit ripple per cycle.
// Latency: out_valid rises PROD_W/SLICE_W clocks after the accepting edge; one op per PROD_W/SLICE_W+2 clocks.
// Backpressure: product held stable in DONE until out_ready; no new operand accepted until then.
// Optional macro BOOTH_FA_OPCNT_EN adds op_count, a wrapping count of completed output handshakes.
module booth_final_adder #(
  parameter int PROD_W  = 16,
  parameter int SLICE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_final_adder_if.slave   bus
`ifdef BOOTH_FA_OPCNT_EN
  ,
  output logic [15:0]          op_count
`endif
);

  localparam int NSL   = PROD_W / SLICE_W;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [PROD_W-1:0] a_op;
  logic [PROD_W-1:0] b_op;
  logic [PROD_W-1:0] prod;
  logic              carry;
  logic [IDX_W-1:0]  idx;

  logic [31:0]       base;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W:0]   sum;

  // Handshake outputs decode straight from state; in_ready is masked during reset.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.product   = prod;

  // Current slice of each operand plus the running carry.
  always_comb begin
    base = 32'(idx) * 32'(SLICE_W);
    a_sl = a_op[base +: SLICE_W];
    b_sl = b_op[base +: SLICE_W];
    sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry};
  end

  // Control FSM and datapath: capture operands, ripple one slice per ADD cycle, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_op  <= '0;
      b_op  <= '0;
      prod  <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_op  <= bus.pp_sum;
            b_op  <= {bus.pp_carry, 2'b00};
            carry <= 1'b0;
            idx   <= '0;
            prod  <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          // Carry out of the top slice is simply overwritten on the next accept: result is mod 2^PROD_W.
          prod[base +: SLICE_W] <= sum[SLICE_W-1:0];
          carry <= sum[SLICE_W];
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOOTH_FA_OPCNT_EN
  logic [15:0] opcnt_q;

  // Count completed output handshakes, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcnt_q <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      opcnt_q <= opcnt_q + 16'd1;
    end
  end

  assign op_count = opcnt_q;
`endif

endmodule

// File: tb/tb_booth_final_adder.sv
// Directed bench for booth_final_adder: expected products are queued when an operand
// pair is issued and a negedge monitor pops and compares on every output handshake.
// Latency/backpressure/reset behaviour is checked directly at posedge+1.
module tb_booth_final_adder;

  logic clk;
  logic rst;

  booth_final_adder_if #(.PROD_W(16)) bus ();

`ifdef BOOTH_FA_OPCNT_EN
  logic [15:0] op_count;
`endif

  booth_final_adder #(.PROD_W(16), .SLICE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef BOOTH_FA_OPCNT_EN
    ,
    .op_count (op_count)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every output handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_out: got %h expected no output", bus.product);
      end else begin
        mon_exp = sb.pop_front();
        chk("product", bus.product, mon_exp);
      end
    end
  end

  // Present an operand pair until accepted; caller is at posedge+1.
  task automatic send(input logic [15:0] s, input logic [13:0] c,
                      input logic [15:0] exp, input bit expect_out);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.pp_sum   = s;
    bus.pp_carry = c;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", 16'(n < 100), 16'd1);
    if (expect_out) sb.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 16'(sb.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.pp_sum    = '0;
    bus.pp_carry  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_product", bus.product, 16'h0000);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 16'(bus.in_ready), 16'd1);
    @(posedge clk); #1;

    // Single op with latency profile: -3*5 = 0xFFF1
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.pp_sum    = 16'hFFF1;
    bus.pp_carry  = 14'h0000;
    chk("idle_in_ready", 16'(bus.in_ready), 16'd1);
    sb.push_back(16'hFFF1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("latency_out_valid", 16'(bus.out_valid), 16'(k == 4));
      chk("busy_in_ready", 16'(bus.in_ready), 16'd0);
    end
    drain();

    // Carry weighting, cross-slice ripple, top-carry wrap, mixed
    send(16'h0003, 14'h0001, 16'h0007, 1'b1);
    send(16'h0FFC, 14'h0001, 16'h1000, 1'b1);
    send(16'hFFFF, 14'h0001, 16'h0003, 1'b1);
    send(16'h8000, 14'h3FFF, 16'h7FFC, 1'b1);
    drain();

    // Backpressure in DONE with new operands waiting
    bus.out_ready = 1'b0;
    send(16'h00F0, 14'h0004, 16'h0100, 1'b1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reach_done", 16'(n < 50), 16'd1);
    bus.in_valid = 1'b1;
    bus.pp_sum   = 16'h0AAA;
    bus.pp_carry = 14'h0001;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 16'(bus.out_valid), 16'd1);
      chk("bp_product", bus.product, 16'h0100);
      chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
    end
    sb.push_back(16'h0AAE);
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_release", 16'(n < 50), 16'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();

    // Reset two cycles after accept abandons the op
    send(16'h5555, 14'h0000, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("midrst_product", bus.product, 16'h0000);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 16'(bus.in_ready), 16'd1);
    repeat (8) @(posedge clk);
    #1;
    send(16'h1234, 14'h0000, 16'h1234, 1'b1);
    drain();
    chk("idle_hold_product", bus.product, 16'h1234);

    // Back-to-back ops with out_ready held high
    send(16'h0001, 14'h0000, 16'h0001, 1'b1);
    send(16'h7FFF, 14'h0001, 16'h8003, 1'b1);
    send(16'h0000, 14'h3FFF, 16'hFFFC, 1'b1);
    drain();

`ifdef BOOTH_FA_OPCNT_EN
    chk("op_count", op_count, 16'd4);
    force dut.opcnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.opcnt_q;
    send(16'h0002, 14'h0000, 16'h0002, 1'b1);
    drain();
    chk("op_count_wrap", op_count, 16'h0000);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
